// File: rtl/img_tx_sequencer.sv
// img_tx_sequencer
//
// Streams the stored IMG_WIDTH x IMG_HEIGHT greyscale image out of the image
// BRAM read port into the UART transmitter, one byte per pixel, in address
// order 0..N-1. For every pixel it presents the address, waits READ_LATENCY
// cycles for the read data, launches the byte and then waits for the rising
// edge of the transmitter's completion flag before moving to the next pixel.
//
// Optional feature: define IMG_TX_CHECKSUM_EN to append one extra byte after
// the last pixel, holding the XOR of all pixels. Without the macro the CKSUM
// state and the checksum register are not built and exactly N bytes are sent.
//
// Ports:
//   clk_in         system clock (single domain)
//   rst_in_n       asynchronous active-low reset
//   start_in       transfer request, honoured only in IDLE with ready_in high
//   ready_in       image present in BRAM
//   abort_in       cancel the transfer in progress (highest priority)
//   bram_addr_out  BRAM port B read address
//   bram_data_in   BRAM port B read data
//   tx_data_out    byte presented to the transmitter
//   tx_start_out   one-cycle launch strobe to the transmitter
//   tx_done_in     transmitter completion flag; rising edge = byte finished
//   busy_out       high from accepted start until back in IDLE
//   done_out       one-cycle pulse once the whole image has been sent
//   pix_count_out  pixels completed in the current / last transfer

module img_tx_sequencer #(
  parameter int IMG_WIDTH    = 128,
  parameter int IMG_HEIGHT   = 128,
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              start_in,
  input  logic              ready_in,
  input  logic              abort_in,
  output logic [ADDR_W-1:0] bram_addr_out,
  input  logic [7:0]        bram_data_in,
  output logic [7:0]        tx_data_out,
  output logic              tx_start_out,
  input  logic              tx_done_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [ADDR_W:0]   pix_count_out
);

  localparam int                N_PIX     = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
  localparam logic [2:0]        LAT_LAST  = 3'(READ_LATENCY - 1);

`ifdef IMG_TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, WAIT_RD, LAUNCH, WAIT_TX, CKSUM, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_RD, LAUNCH, WAIT_TX, FINISH} state_t;
`endif

  state_t     state;
  logic [2:0] lat_cnt;
  logic       tx_done_p1;
  logic       tx_done_rise;

`ifdef IMG_TX_CHECKSUM_EN
  logic [7:0] cksum;
  logic       cksum_wait;  // checksum byte launched, waiting for its completion
`endif

  // completion edge against the previous-cycle sample of tx_done_in
  assign tx_done_rise = tx_done_in & ~tx_done_p1;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      tx_done_p1    <= 1'b0;
      bram_addr_out <= '0;
      tx_data_out   <= '0;
      tx_start_out  <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      pix_count_out <= '0;
`ifdef IMG_TX_CHECKSUM_EN
      cksum         <= '0;
      cksum_wait    <= 1'b0;
`endif
    end else begin
      tx_done_p1   <= tx_done_in;
      tx_start_out <= 1'b0;
      done_out     <= 1'b0;
      if (abort_in && (state != IDLE)) begin
        // a byte already launched finishes on the line; we just stop here
        state         <= IDLE;
        busy_out      <= 1'b0;
        bram_addr_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            bram_addr_out <= '0;
            // busy_out is still high in the IDLE cycle right after FINISH,
            // so a start landing on that cycle is ignored
            if (start_in && ready_in && !busy_out) begin
              state         <= WAIT_RD;
              busy_out      <= 1'b1;
              lat_cnt       <= '0;
              pix_count_out <= '0;
`ifdef IMG_TX_CHECKSUM_EN
              cksum         <= '0;
`endif
            end else begin
              busy_out <= 1'b0;
            end
          end
          WAIT_RD: begin
            if (lat_cnt == LAT_LAST) state <= LAUNCH;
            else lat_cnt <= lat_cnt + 3'd1;
          end
          LAUNCH: begin
            tx_data_out  <= bram_data_in;
            tx_start_out <= 1'b1;
`ifdef IMG_TX_CHECKSUM_EN
            cksum        <= cksum ^ bram_data_in;
`endif
            state        <= WAIT_TX;
          end
          WAIT_TX: begin
            if (tx_done_rise) begin
              pix_count_out <= pix_count_out + (ADDR_W + 1)'(1);
              if (bram_addr_out == LAST_ADDR) begin
`ifdef IMG_TX_CHECKSUM_EN
                state      <= CKSUM;
                cksum_wait <= 1'b0;
`else
                state      <= FINISH;
`endif
              end else begin
                bram_addr_out <= bram_addr_out + ADDR_W'(1);
                lat_cnt       <= '0;
                state         <= WAIT_RD;
              end
            end
          end
`ifdef IMG_TX_CHECKSUM_EN
          CKSUM: begin
            if (!cksum_wait) begin
              tx_data_out  <= cksum;
              tx_start_out <= 1'b1;
              cksum_wait   <= 1'b1;
            end else if (tx_done_rise) begin
              state <= FINISH;
            end
          end
`endif
          FINISH: begin
            done_out      <= 1'b1;
            bram_addr_out <= '0;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/img_tx_sequencer.md
# img_tx_sequencer

Controller that streams the stored 128x128 greyscale image out of the image BRAM's read port into the UART transmitter, one byte per pixel, in address order 0..N-1. It owns BRAM port B addressing and the transmitter's start/data inputs, and replaces ad-hoc counter logic in the top level. It waits the BRAM's read latency and the transmitter's completion strobe between pixels. It can also append a checksum byte.

## Interface
Parameters:
- IMG_WIDTH, 128, pixels per row
- IMG_HEIGHT, 128, rows
- ADDR_W, 14, BRAM address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT
- READ_LATENCY, 2, cycles from address change to valid bram_data_in (1..7)

Ports:
- clk_in  in  1  system clock; single clock domain
- rst_in_n  in  1  asynchronous, active-low reset
- start_in  in  1  request to transmit image; sampled every cycle
- ready_in  in  1  image present in BRAM; start_in is ignored while low
- abort_in  in  1  cancel an in-progress transfer
- bram_addr_out  out  ADDR_W  BRAM read address
- bram_data_in  in  8  BRAM read data
- tx_data_out  out  8  byte to transmitter
- tx_start_out  out  1  one-cycle launch strobe to transmitter
- tx_done_in  in  1  transmitter completion; its rising edge marks byte finished
- busy_out  out  1  high from accepted start until return to IDLE
- done_out  out  1  one-cycle pulse when full image (and checksum) sent
- pix_count_out  out  ADDR_W+1  pixels whose transmission completed in current/last transfer

## Operation
- States: IDLE, WAIT_RD, LAUNCH, WAIT_TX, CKSUM, FINISH.
- IDLE: bram_addr_out=0, busy_out=0. start_in=1 and ready_in=1 -> WAIT_RD; latency counter cleared, pix_count_out cleared, checksum cleared. Start with ready_in=0 is dropped, not queued.
- WAIT_RD: count READ_LATENCY cycles with the address stable, then -> LAUNCH.
- LAUNCH: tx_data_out<=bram_data_in; tx_start_out=1 for this cycle only; checksum ^= bram_data_in -> WAIT_TX.
- WAIT_TX: wait for a rising edge of tx_done_in (registered previous value, updated every cycle; an edge in the LAUNCH cycle itself is ignored). On edge: pix_count_out+1.
  - If the address was not last (IMG_WIDTH*IMG_HEIGHT-1): address+1 -> WAIT_RD.
  - If it was last: -> CKSUM when CHECKSUM is compiled in, else -> FINISH.
- CKSUM: one LAUNCH-style cycle with tx_data_out=checksum, then wait for a tx_done_in rising edge -> FINISH. pix_count_out is not incremented.
- FINISH: done_out=1 for one cycle -> IDLE.
- start_in while busy_out=1 is ignored.
- abort_in=1 in any non-IDLE state: next state IDLE, no done_out, tx_start_out forced 0 that cycle. A byte already launched completes on the line. Abort has priority over every other transition.
- Address arithmetic is unsigned. The address never wraps mid-transfer; the last address is compared explicitly. pix_count_out holds its value in IDLE until the next accepted start.

## Timing
- Reset (async assert, sync release) values: state IDLE, bram_addr_out=0, tx_data_out=0, tx_start_out=0, busy_out=0, done_out=0, pix_count_out=0, checksum 0.
- Start accepted at edge k: busy_out=1 after k. tx_start_out is high during the cycle after edge k+READ_LATENCY+1.
- Per pixel: READ_LATENCY+1 cycles plus transmitter time.
- done_out rises the cycle after the final completion edge enters FINISH. busy_out drops together with done_out's fall.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- IMG_TX_CHECKSUM_EN defined: after the last pixel, one extra byte is sent: the XOR of all IMG_WIDTH*IMG_HEIGHT pixels. Total bytes sent = N+1.
- IMG_TX_CHECKSUM_EN undefined: the CKSUM state is absent, exactly N bytes are sent, and the checksum register is not built.

## Test plan
- Reset mid-transfer: assert rst_in_n=0 at pixel 37 -> all outputs at reset values immediately; no further tx_start_out after release.
- Full image, IMG 4x4 override, BRAM loaded with 0x10..0x1F, transmitter model done 20 cycles after start -> 16 strobes, data 0x10..0x1F in order, pix_count_out=16, done_out single pulse.
- Same with IMG_TX_CHECKSUM_EN -> 17th byte 0x00 (XOR of 0x10..0x1F), pix_count_out=16.
- start_in with ready_in=0 -> no state change, busy_out stays 0. A start_in pulse repeated during transfer -> ignored, exactly 16 bytes.
- abort_in at pixel 5 while in WAIT_TX -> IDLE next cycle, no done_out, pix_count_out=5. A new start then begins at address 0.
- READ_LATENCY=1 and 3 -> tx_start_out at k+2 and k+4 respectively; data matches BRAM contents.
